// File: rtl/instr_boot_loader_if.sv
// Byte stream from the UART receiver plus the instruction-memory write port.
// The loader is the master and drives the memory write signals.
interface instr_boot_loader_if #(
    parameter int ADDR_W = 6
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/instr_boot_loader.sv
// Power-up sequencer: holds the CPU in reset while a little-endian UART byte
// stream is assembled into 32-bit words and written into instruction memory.
module instr_boot_loader #(
    parameter int DEPTH_WORDS    = 64,
    parameter int ADDR_W         = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    instr_boot_loader_if.master bus,
    input  logic                skip_boot,
    input  logic                reload,
    output logic                cpu_reset,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [15:0]         words_loaded
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]      DEPTH_N  = 17'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR1  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [7:0]        n_lo_r, n_lo_s;
    logic [15:0]       n_r, n_s;
    logic [1:0]        byte_idx_r, byte_idx_s;
    logic [23:0]       word_buf_r, word_buf_s;
    logic              last_r, last_s;
    logic [TMO_W-1:0]  tmo_r, tmo_s;
    logic              tmo_expire_s;
    logic              imem_we_r, imem_we_s;
    logic [ADDR_W-1:0] imem_addr_r, imem_addr_s;
    logic [31:0]       imem_wdata_r, imem_wdata_s;
    logic [15:0]       words_loaded_r, words_loaded_s;
    logic              cpu_reset_r, cpu_reset_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              err_r, err_s;

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        state_s        = state_r;
        n_lo_s         = n_lo_r;
        n_s            = n_r;
        byte_idx_s     = byte_idx_r;
        word_buf_s     = word_buf_r;
        last_s         = 1'b0;
        imem_we_s      = 1'b0;
        imem_addr_s    = imem_addr_r;
        imem_wdata_s   = imem_wdata_r;
        words_loaded_s = words_loaded_r;
        tmo_expire_s   = (tmo_r == TMO_LAST) && !bus.rx_valid;

        case (state_r)
            ST_IDLE: begin
                if (skip_boot) begin
                    state_s = ST_RUN;
                end else if (bus.rx_valid) begin
                    n_lo_s  = bus.rx_data;
                    state_s = ST_HDR1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HDR1: begin
                if (bus.rx_valid) begin
                    n_s            = {bus.rx_data, n_lo_r};
                    byte_idx_s     = 2'd0;
                    words_loaded_s = 16'd0;
                    if (n_s == 16'd0) begin
                        state_s = ST_RUN;
                    end else if ({1'b0, n_s} > DEPTH_N) begin
                        state_s = ST_ERROR;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else if (tmo_expire_s) begin
                    state_s = ST_ERROR;
                end else begin
                    state_s = ST_HDR1;
                end
            end
            ST_LOAD: begin
                // last_r marks the cycle the final word is on the write port.
                if (last_r) begin
                    state_s = ST_RUN;
                end else if (bus.rx_valid) begin
                    byte_idx_s = byte_idx_r + 2'd1;
                    case (byte_idx_r)
                        2'd0:    word_buf_s[7:0]   = bus.rx_data;
                        2'd1:    word_buf_s[15:8]  = bus.rx_data;
                        2'd2:    word_buf_s[23:16] = bus.rx_data;
                        default: begin
                            imem_we_s      = 1'b1;
                            imem_addr_s    = words_loaded_r[ADDR_W-1:0];
                            imem_wdata_s   = {bus.rx_data, word_buf_r};
                            words_loaded_s = words_loaded_r + 16'd1;
                            last_s         = (words_loaded_s == n_r);
                        end
                    endcase
                end else if (tmo_expire_s) begin
                    state_s = ST_ERROR;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (reload) begin
                    state_s        = ST_IDLE;
                    words_loaded_s = 16'd0;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_ERROR: begin
                if (reload) begin
                    state_s        = ST_IDLE;
                    words_loaded_s = 16'd0;
                end else begin
                    state_s = ST_ERROR;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Idle counter only advances while a transfer is open and the line is quiet.
        if (((state_s == ST_HDR1) || (state_s == ST_LOAD)) && !bus.rx_valid) begin
            tmo_s = tmo_r + TMO_W'(1);
        end else begin
            tmo_s = {TMO_W{1'b0}};
        end

        cpu_reset_s = (state_s != ST_RUN);
        busy_s      = (state_s == ST_HDR1) || (state_s == ST_LOAD);
        done_s      = (state_s == ST_RUN);
        err_s       = (state_s == ST_ERROR);
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            n_lo_r         <= 8'd0;
            n_r            <= 16'd0;
            byte_idx_r     <= 2'd0;
            word_buf_r     <= 24'd0;
            last_r         <= 1'b0;
            tmo_r          <= {TMO_W{1'b0}};
            imem_we_r      <= 1'b0;
            imem_addr_r    <= {ADDR_W{1'b0}};
            imem_wdata_r   <= 32'd0;
            words_loaded_r <= 16'd0;
            cpu_reset_r    <= 1'b1;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            state_r        <= state_s;
            n_lo_r         <= n_lo_s;
            n_r            <= n_s;
            byte_idx_r     <= byte_idx_s;
            word_buf_r     <= word_buf_s;
            last_r         <= last_s;
            tmo_r          <= tmo_s;
            imem_we_r      <= imem_we_s;
            imem_addr_r    <= imem_addr_s;
            imem_wdata_r   <= imem_wdata_s;
            words_loaded_r <= words_loaded_s;
            cpu_reset_r    <= cpu_reset_s;
            busy_r         <= busy_s;
            done_r         <= done_s;
            err_r          <= err_s;
        end
    end

    assign bus.imem_we    = imem_we_r;
    assign bus.imem_addr  = imem_addr_r;
    assign bus.imem_wdata = imem_wdata_r;
    assign cpu_reset      = cpu_reset_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign err            = err_r;
    assign words_loaded   = words_loaded_r;

endmodule
